// File: rtl/moore_seq_pkg.sv
// ============================================================================
// Module : moore_seq_pkg
// Brief  : Shared types and default sizing for the Moore sequence player.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package moore_seq_pkg;

    localparam int SYM_W     = 4;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;
    localparam int DEF_CW    = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLAY  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/moore_seq_buf.sv
// ============================================================================
// Module : moore_seq_buf
// Brief  : DEPTH x 4 symbol buffer with append-only write, flush, length
//          tracking and a combinational read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_seq_buf
    import moore_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [SYM_W-1:0] i_wr_data,
    input  logic             i_flush,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [SYM_W-1:0] o_rd_data,
    output logic [AW:0]      o_len,
    output logic             o_wr_full
);

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_len;
    logic             w_wr_ok;

    // DEPTH is a power of two, so the MSB of the length marks "full".
    assign o_wr_full = r_len[AW];
    assign w_wr_ok   = i_wr_en && !i_flush && !r_len[AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
        end else if (i_flush) begin
            r_len <= '0;
        end else if (w_wr_ok) begin
            r_len <= r_len + {{AW{1'b0}}, 1'b1};
        end
    end

    // The write pointer is the current length; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_len[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_len     = r_len;

endmodule

`default_nettype wire

// File: rtl/moore_seq_player.sv
// ============================================================================
// Module : moore_seq_player
// Brief  : Plays buffered 4-bit symbols into a Moore detector and counts the
//          hits aligned to each symbol. MOORE_SEQ_FIRSTHIT_EN adds first-hit
//          index reporting.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_seq_player
    import moore_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int CW    = DEF_CW
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [SYM_W-1:0] wr_data,
    input  logic             flush,
    input  logic             start,
    input  logic             det_hit,
    output logic             wr_full,
    output logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             det_clr,
    output logic [CW-1:0]    match_count
`ifdef MOORE_SEQ_FIRSTHIT_EN
    ,
    output logic             first_hit_valid,
    output logic [AW-1:0]    first_hit_idx
`endif
);

    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_sym_valid_d;
    logic [CW-1:0]    r_match_count;
    logic [SYM_W-1:0] w_rd_data;
    logic [AW:0]      w_len;
    logic             w_idle;
    logic             w_play;
    logic             w_start_ok;
    logic             w_last;
    logic             w_hit;

    assign w_idle     = (r_state == IDLE);
    assign w_play     = (r_state == PLAY);
    assign w_start_ok = w_idle && start;
    assign w_last     = ({1'b0, r_rd_ptr} == (w_len - c_LEN_ONE));
    // A Moore hit shows up the cycle after its symbol was presented.
    assign w_hit      = det_hit && r_sym_valid_d;

    moore_seq_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk       (CLK),
        .rst       (Reset),
        .i_wr_en   (wr_en && w_idle),
        .i_wr_data (wr_data),
        .i_flush   (flush && w_idle),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data),
        .o_len     (w_len),
        .o_wr_full (wr_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = (w_len != '0) ? PLAY : DRAIN;
            PLAY:    if (w_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_rd_ptr      <= '0;
            r_sym_valid_d <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sym_valid_d <= w_play;
            if (w_start_ok) begin
                r_rd_ptr <= '0;
            end else if (w_play) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_start_ok) begin
                r_match_count <= '0;
            end else if (w_hit && (r_match_count != c_CNT_MAX)) begin
                r_match_count <= r_match_count + c_CNT_ONE;
            end
        end
    end

`ifdef MOORE_SEQ_FIRSTHIT_EN
    logic [AW-1:0] r_rd_ptr_d;
    logic          r_fh_valid;
    logic [AW-1:0] r_fh_idx;

    // r_rd_ptr_d names the symbol whose completion produced the current hit.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_rd_ptr_d <= '0;
            r_fh_valid <= 1'b0;
            r_fh_idx   <= '0;
        end else begin
            r_rd_ptr_d <= r_rd_ptr;
            if (w_start_ok || (r_state == CLEAR)) begin
                r_fh_valid <= 1'b0;
                r_fh_idx   <= '0;
            end else if (w_hit && !r_fh_valid) begin
                r_fh_valid <= 1'b1;
                r_fh_idx   <= r_rd_ptr_d;
            end
        end
    end

    assign first_hit_valid = r_fh_valid;
    assign first_hit_idx   = r_fh_idx;
`endif

    assign len         = w_len;
    assign busy        = !w_idle;
    assign done        = (r_state == DONE);
    assign det_clr     = (r_state == CLEAR);
    assign sym_valid   = w_play;
    assign sym_out     = w_play ? w_rd_data : '0;
    assign match_count = r_match_count;

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_player.sv
// ============================================================================
// Module : tb_moore_seq_player
// Brief  : Directed bench for moore_seq_player with a stub 3->7 detector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moore_seq_player;
    import moore_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          wr_en;
    logic [3:0]    wr_data;
    logic          flush;
    logic          start;
    logic          det_hit;
    logic          wr_full;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [3:0]    sym_out;
    logic          sym_valid;
    logic          det_clr;
    logic [CW-1:0] match_count;
`ifdef MOORE_SEQ_FIRSTHIT_EN
    logic          first_hit_valid;
    logic [AW-1:0] first_hit_idx;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    moore_seq_player #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .start       (start),
        .det_hit     (det_hit),
        .wr_full     (wr_full),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .det_clr     (det_clr),
        .match_count (match_count)
`ifdef MOORE_SEQ_FIRSTHIT_EN
        ,
        .first_hit_valid (first_hit_valid),
        .first_hit_idx   (first_hit_idx)
`endif
    );

    // Stub Moore detector: output high in the state after the pair 3,7.
    logic r_prev3;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_prev3 <= 1'b0;
            det_hit <= 1'b0;
        end else if (det_clr) begin
            r_prev3 <= 1'b0;
            det_hit <= 1'b0;
        end else begin
            det_hit <= r_prev3 && (sym_out == 4'h7);
            r_prev3 <= (sym_out == 4'h3);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic flush_buf();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic load5();
        logic [3:0] s [5] = '{4'h3, 4'h7, 4'h1, 4'h3, 4'h7};
        flush_buf();
        for (int i = 0; i < 5; i++) load(s[i]);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2;
        n_cmp++;
        if ({busy, done, det_clr, sym_valid, wr_full} !== 5'b0 || sym_out !== 4'h0 ||
            len !== '0 || match_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b clr=%b sv=%b full=%b sym=%h len=%0d cnt=%0d (want all 0)",
                     busy, done, det_clr, sym_valid, wr_full, sym_out, len, match_count);
        end
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_play();
        logic [3:0] s [5] = '{4'h3, 4'h7, 4'h1, 4'h3, 4'h7};
        load5();
        n_cmp++;
        if (len !== 5'd5) begin
            n_err++;
            $display("FAIL play_len: got %0d want 5", len);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (det_clr !== 1'b1 || busy !== 1'b1 || sym_valid !== 1'b0) begin
            n_err++;
            $display("FAIL play_clear_c1: clr=%b busy=%b sv=%b want 1 1 0", det_clr, busy, sym_valid);
        end
        for (int c = 2; c <= 9; c++) begin
            tick();
            n_cmp++;
            if (c <= 6) begin
                if (sym_valid !== 1'b1 || sym_out !== s[c-2] || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL play_sym_c%0d: sv=%b sym=%h done=%b want 1 %h 0",
                             c, sym_valid, sym_out, done, s[c-2]);
                end
            end else begin
                if (sym_valid !== 1'b0 || sym_out !== 4'h0 || done !== (c == 8) || busy !== (c != 9)) begin
                    n_err++;
                    $display("FAIL play_tail_c%0d: sv=%b sym=%h done=%b busy=%b want 0 0 %b %b",
                             c, sym_valid, sym_out, done, busy, (c == 8), (c != 9));
                end
            end
        end
        n_cmp++;
        if (match_count !== 5'd2) begin
            n_err++;
            $display("FAIL play_count: got %0d want 2", match_count);
        end
        // Replay of the retained buffer must give the same result.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        n_cmp++;
        if (done !== 1'b1 || match_count !== 5'd2) begin
            n_err++;
            $display("FAIL replay: done=%b cnt=%0d want 1 2", done, match_count);
        end
        tick();
    endtask

    task automatic test_empty();
        flush_buf();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (det_clr !== 1'b1 || sym_valid !== 1'b0 || match_count !== '0) begin
            n_err++;
            $display("FAIL empty_c1: clr=%b sv=%b cnt=%0d want 1 0 0", det_clr, sym_valid, match_count);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (sym_valid !== 1'b0 || done !== (c == 3) || det_clr !== 1'b0) begin
                n_err++;
                $display("FAIL empty_c%0d: sv=%b done=%b clr=%b want 0 %b 0", c, sym_valid, done, det_clr, (c == 3));
            end
        end
        n_cmp++;
        if (match_count !== '0) begin
            n_err++;
            $display("FAIL empty_count: got %0d want 0", match_count);
        end
        tick();
    endtask

    task automatic test_full();
        logic [3:0] d;
        flush_buf();
        for (int i = 0; i < 16; i++) begin
            d = 4'(i) ^ 4'h5;
            n_cmp++;
            if (wr_full !== 1'b0) begin
                n_err++;
                $display("FAIL full_early_%0d: wr_full=%b want 0", i, wr_full);
            end
            load(d);
        end
        n_cmp++;
        if (wr_full !== 1'b1 || len !== 5'd16) begin
            n_err++;
            $display("FAIL full_16: full=%b len=%0d want 1 16", wr_full, len);
        end
        load(4'hA);
        n_cmp++;
        if (len !== 5'd16) begin
            n_err++;
            $display("FAIL full_17th: len=%0d want 16", len);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 19; c++) begin
            tick();
            d = 4'(c - 2) ^ 4'h5;
            if (c <= 17) begin
                n_cmp++;
                if (sym_valid !== 1'b1 || sym_out !== d) begin
                    n_err++;
                    $display("FAIL full_sym_c%0d: sv=%b sym=%h want 1 %h", c, sym_valid, sym_out, d);
                end
            end else begin
                n_cmp++;
                if (sym_valid !== 1'b0 || done !== (c == 19)) begin
                    n_err++;
                    $display("FAIL full_tail_c%0d: sv=%b done=%b want 0 %b", c, sym_valid, done, (c == 19));
                end
            end
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        load5();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            if (c == 3) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_data = 4'hF;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            n_cmp++;
            if (len !== 5'd5 || done !== (c == 8) || det_clr !== 1'b0 || busy !== (c <= 8)) begin
                n_err++;
                $display("FAIL busy_c%0d: len=%0d done=%b clr=%b busy=%b want 5 %b 0 %b",
                         c, len, done, det_clr, busy, (c == 8), (c <= 8));
            end
        end
        n_cmp++;
        if (match_count !== 5'd2) begin
            n_err++;
            $display("FAIL busy_count: got %0d want 2", match_count);
        end
    endtask

    task automatic test_reset_midrun();
        load5();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 4; c++) tick();
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, det_clr, sym_valid, wr_full} !== 5'b0 || sym_out !== 4'h0 ||
            len !== '0 || match_count !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b clr=%b sv=%b sym=%h len=%0d cnt=%0d want all 0",
                     busy, done, det_clr, sym_valid, sym_out, len, match_count);
        end
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrun_nodone_%0d: done=%b busy=%b want 0 0", c, done, busy);
            end
        end
        load(4'h3);
        load(4'h7);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        n_cmp++;
        if (done !== 1'b1 || match_count !== 5'd1) begin
            n_err++;
            $display("FAIL midrun_rerun: done=%b cnt=%0d want 1 1", done, match_count);
        end
        tick();
    endtask

`ifdef MOORE_SEQ_FIRSTHIT_EN
    task automatic test_firsthit();
        logic [3:0] s [5] = '{4'h1, 4'h3, 4'h7, 4'h3, 4'h7};
        flush_buf();
        for (int i = 0; i < 5; i++) load(s[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (first_hit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fh_clear: valid=%b want 0", first_hit_valid);
        end
        for (int c = 2; c <= 8; c++) tick();
        n_cmp++;
        if (first_hit_valid !== 1'b1 || first_hit_idx !== 4'd2 || match_count !== 5'd2) begin
            n_err++;
            $display("FAIL fh_result: valid=%b idx=%0d cnt=%0d want 1 2 2",
                     first_hit_valid, first_hit_idx, match_count);
        end
        tick();
    endtask
`endif

    initial begin
        Reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 4'h0;
        flush   = 1'b0;
        start   = 1'b0;
        test_reset();
        test_play();
        test_empty();
        test_full();
        test_busy_ignore();
        test_reset_midrun();
`ifdef MOORE_SEQ_FIRSTHIT_EN
        test_firsthit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
